rr_mux_pipe: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshaking. It generalises the datapath 2-to-1 select into an arbitrated, one-stage-pipelined merge point. In round-robin mode it fairly merges several producer streams into one consumer. In fixed mode it behaves as a registered N-to-1 mux steered by `sel`. It sits between the datapath sources and a single shared sink, for example the register-file write port or the memory request port.

---
 rtl/rr_mux_pipe_if.sv | 28 ++
 rtl/rr_mux_pipe.sv | 91 +++++++++
 tb/tb_rr_mux_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_mux_pipe_if.sv
// Valid/ready bundle between N producers, the rr_mux_pipe merge point and one consumer.
// The master drives the producer and consumer side. The slave is the merge block itself.
interface rr_mux_pipe_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic                      mode;
    logic [SELW-1:0]           sel;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SELW-1:0]           out_ch;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_mux_pipe.sv
// rr_mux_pipe: N-to-1 valid/ready merge with a single registered output stage.
// mode=0 arbitrates round-robin from ptr; mode=1 steers from channel sel.
module rr_mux_pipe #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic         clk,
    input  logic         rst,
    rr_mux_pipe_if.slave bus
);
    localparam int SELW = $clog2(CHANNELS);
    localparam int NPAD = 1 << SELW;

    logic [SELW-1:0]     ptr;
    logic [SELW-1:0]     ptr_next;
    logic [SELW-1:0]     g;
    logic [SELW-1:0]     rr_idx;
    logic                grant;
    logic                load;
    logic                take;
    logic [NPAD-1:0]     valid_pad;
    logic [CHANNELS-1:0] ready_c;
    logic [WIDTH-1:0]    g_data;
    logic                out_valid_q;
    logic [WIDTH-1:0]    out_data_q;
    logic [SELW-1:0]     out_ch_q;

    // Zero padding up to 2**SELW makes any sel >= CHANNELS see an idle channel.
    assign valid_pad = NPAD'(bus.in_valid);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant  = 1'b0;
        g      = '0;
        rr_idx = '0;
        if (bus.mode) begin
            grant = valid_pad[bus.sel];
            g     = bus.sel;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                rr_idx = (int'(ptr) + i >= CHANNELS) ? SELW'(int'(ptr) + i - CHANNELS)
                                                     : SELW'(int'(ptr) + i);
                if (!grant && valid_pad[rr_idx]) begin
                    grant = 1'b1;
                    g     = rr_idx;
                end
            end
        end
    end

    assign load = !out_valid_q || bus.out_ready;
    assign take = grant && load && !rst;

    always_comb begin
        ready_c = '0;
        g_data  = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ready_c[k] = take && (g == SELW'(k));
            if (g == SELW'(k)) begin
                g_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Explicit wrap keeps non power-of-two channel counts inside 0..CHANNELS-1.
    assign ptr_next = (g == SELW'(CHANNELS - 1)) ? '0 : g + SELW'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr         <= '0;
        end else if (take) begin
            out_valid_q <= 1'b1;
            out_data_q  <= g_data;
            out_ch_q    <= g;
            if (!bus.mode) begin
                ptr <= ptr_next;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_rr_mux_pipe.sv
// Bench for rr_mux_pipe: a 4-channel and a 5-channel instance, directed scenarios plus
// random traffic compared against a transaction-level model of grant, pointer and output register.
module tb_rr_mux_pipe;
    logic clk = 1'b0;
    logic rst4;
    logic rst5;

    rr_mux_pipe_if #(.WIDTH(32), .CHANNELS(4)) bus4 ();
    rr_mux_pipe_if #(.WIDTH(32), .CHANNELS(5)) bus5 ();

    rr_mux_pipe #(.WIDTH(32), .CHANNELS(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
    rr_mux_pipe #(.WIDTH(32), .CHANNELS(5)) dut5 (.clk(clk), .rst(rst5), .bus(bus5));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model state for each instance: index 0 = 4 channels, index 1 = 5 channels.
    int          nch[2]  = '{4, 5};
    int          selw[2] = '{2, 3};
    int          m_ptr[2];
    bit          m_ov[2];
    logic [31:0] m_data[2];
    int          m_ch[2];
    int          g_exp[2];
    logic [15:0] exp_rdy[2];
    logic [31:0] din[2][16];
    bit          cur_rst[2];
    bit          cur_mode[2];
    bit          cur_ordy[2];

    function automatic int model_grant(input int n, input bit md, input int s,
                                       input logic [15:0] v, input int p);
        if (md) return (s < n && v[4'(s)]) ? s : -1;
        for (int i = 0; i < n; i++) begin
            if (v[4'((p + i) % n)]) return (p + i) % n;
        end
        return -1;
    endfunction

    function automatic logic [15:0] obs_ready(input int w);
        return (w == 0) ? 16'(bus4.in_ready) : 16'(bus5.in_ready);
    endfunction

    function automatic logic [36:0] obs_out(input int w);
        return (w == 0) ? {bus4.out_valid, 4'(bus4.out_ch), bus4.out_data}
                        : {bus5.out_valid, 4'(bus5.out_ch), bus5.out_data};
    endfunction

    function automatic logic [36:0] exp_out(input int w);
        return {m_ov[w], 4'(m_ch[w]), m_data[w]};
    endfunction

    // Drive one cycle of inputs at the falling edge and predict in_ready.
    task automatic apply(input int w, input bit r, input bit md, input int s,
                         input logic [15:0] v, input bit ordy, input bit pat);
        logic [15:0] vm;
        int          sm;
        @(negedge clk);
        vm = v & 16'((1 << nch[w]) - 1);
        sm = s & ((1 << selw[w]) - 1);
        for (int k = 0; k < nch[w]; k++) begin
            din[w][k] = pat ? (32'hA000_0000 | 32'(k)) : $urandom();
        end
        if (w == 0) begin
            rst4 = r; bus4.mode = md; bus4.sel = 2'(sm); bus4.in_valid = vm[3:0];
            bus4.out_ready = ordy;
            for (int k = 0; k < 4; k++) bus4.in_data[k*32 +: 32] = din[0][k];
        end else begin
            rst5 = r; bus5.mode = md; bus5.sel = 3'(sm); bus5.in_valid = vm[4:0];
            bus5.out_ready = ordy;
            for (int k = 0; k < 5; k++) bus5.in_data[k*32 +: 32] = din[1][k];
        end
        if (r || (m_ov[w] && !ordy)) g_exp[w] = -1;
        else                         g_exp[w] = model_grant(nch[w], md, sm, vm, m_ptr[w]);
        exp_rdy[w]  = (g_exp[w] < 0) ? 16'h0 : (16'h1 << g_exp[w]);
        cur_rst[w]  = r;
        cur_mode[w] = md;
        cur_ordy[w] = ordy;
        #1;
    endtask

    // Advance past the rising edge and update the model's output register and pointer.
    task automatic clock(input int w);
        @(posedge clk);
        if (cur_rst[w]) begin
            m_ov[w] = 1'b0; m_data[w] = '0; m_ch[w] = 0; m_ptr[w] = 0;
        end else if (g_exp[w] >= 0) begin
            m_ov[w]   = 1'b1;
            m_data[w] = din[w][g_exp[w]];
            m_ch[w]   = g_exp[w];
            if (!cur_mode[w]) m_ptr[w] = (g_exp[w] + 1) % nch[w];
        end else if (cur_ordy[w]) begin
            m_ov[w] = 1'b0;
        end
        #1;
    endtask

    task automatic reset2(input int w);
        for (int i = 0; i < 2; i++) begin
            apply(w, 1, 0, 0, 16'hFFFF, 1, 1);
            clock(w);
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 2; i++) begin
            apply(0, 1, 0, 0, 16'hFFFF, 1, 1);
            n_vec++;
            if (bus4.in_ready !== 4'b0000) begin
                n_err++; $display("FAIL reset_in_ready: got %b expected 0000", bus4.in_ready);
            end
            clock(0);
            n_vec++;
            if ({bus4.out_valid, bus4.out_ch, bus4.out_data} !== 35'd0) begin
                n_err++; $display("FAIL reset_outputs: got v=%b ch=%0d d=%h expected all zero",
                                  bus4.out_valid, bus4.out_ch, bus4.out_data);
            end
        end
        apply(0, 0, 0, 0, 16'hFFFF, 1, 1);
        n_vec++;
        if (bus4.in_ready !== 4'b0001) begin
            n_err++; $display("FAIL reset_first_ready: got %b expected 0001", bus4.in_ready);
        end
        clock(0);
        n_vec++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd0 || bus4.out_data !== 32'hA000_0000) begin
            n_err++; $display("FAIL reset_first_grant: got v=%b ch=%0d d=%h expected 1/0/a0000000",
                              bus4.out_valid, bus4.out_ch, bus4.out_data);
        end
    endtask

    task automatic test_fairness;
        reset2(0);
        for (int i = 0; i < 8; i++) begin
            apply(0, 0, 0, 0, 16'hFFFF, 1, 1);
            n_vec++;
            if (bus4.in_ready !== 4'(1 << (i % 4))) begin
                n_err++; $display("FAIL fair_ready[%0d]: got %b expected %b",
                                  i, bus4.in_ready, 4'(1 << (i % 4)));
            end
            clock(0);
            n_vec++;
            if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'(i % 4) ||
                bus4.out_data !== (32'hA000_0000 | 32'(i % 4))) begin
                n_err++; $display("FAIL fair_out[%0d]: got v=%b ch=%0d d=%h expected ch=%0d",
                                  i, bus4.out_valid, bus4.out_ch, bus4.out_data, i % 4);
            end
        end
    endtask

    task automatic test_skip_idle;
        reset2(0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 0, 16'b1010, 1, 1);
            clock(0);
            n_vec++;
            if (bus4.out_valid !== 1'b1 || bus4.out_ch !== ((i % 2 == 0) ? 2'd1 : 2'd3)) begin
                n_err++; $display("FAIL skip_seq[%0d]: got v=%b ch=%0d expected ch=%0d",
                                  i, bus4.out_valid, bus4.out_ch, (i % 2 == 0) ? 1 : 3);
            end
        end
        reset2(0);
        apply(0, 0, 0, 0, 16'b0010, 1, 1);
        clock(0);
        apply(0, 0, 0, 0, 16'b1010, 1, 1);
        n_vec++;
        if (bus4.in_ready !== 4'b1000) begin
            n_err++; $display("FAIL skip_ptr2_ready: got %b expected 1000", bus4.in_ready);
        end
        clock(0);
        n_vec++;
        if (bus4.out_ch !== 2'd3 || bus4.out_data !== 32'hA000_0003) begin
            n_err++; $display("FAIL skip_ptr2_out: got ch=%0d d=%h expected 3/a0000003",
                              bus4.out_ch, bus4.out_data);
        end
    endtask

    task automatic test_backpressure;
        reset2(0);
        apply(0, 0, 0, 0, 16'hFFFF, 1, 1);
        clock(0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 16'hFFFF, 0, 1);
            n_vec++;
            if (bus4.in_ready !== 4'b0000) begin
                n_err++; $display("FAIL bp_ready[%0d]: got %b expected 0000", i, bus4.in_ready);
            end
            clock(0);
            n_vec++;
            if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd0 || bus4.out_data !== 32'hA000_0000) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%h expected 1/0/a0000000",
                                  i, bus4.out_valid, bus4.out_ch, bus4.out_data);
            end
        end
        apply(0, 0, 0, 0, 16'hFFFF, 1, 1);
        n_vec++;
        if (bus4.in_ready !== 4'b0010) begin
            n_err++; $display("FAIL bp_release_ready: got %b expected 0010", bus4.in_ready);
        end
        clock(0);
        n_vec++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd1 || bus4.out_data !== 32'hA000_0001) begin
            n_err++; $display("FAIL bp_release_out: got v=%b ch=%0d d=%h expected 1/1/a0000001",
                              bus4.out_valid, bus4.out_ch, bus4.out_data);
        end
    endtask

    task automatic test_fixed;
        reset2(0);
        apply(0, 0, 0, 0, 16'hFFFF, 1, 1);
        clock(0);
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 2, 16'hFFFF, 1, 1);
            n_vec++;
            if (bus4.in_ready !== 4'b0100) begin
                n_err++; $display("FAIL fixed_ready[%0d]: got %b expected 0100", i, bus4.in_ready);
            end
            clock(0);
            n_vec++;
            if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd2 || bus4.out_data !== 32'hA000_0002) begin
                n_err++; $display("FAIL fixed_out[%0d]: got v=%b ch=%0d d=%h expected 1/2/a0000002",
                                  i, bus4.out_valid, bus4.out_ch, bus4.out_data);
            end
        end
        apply(0, 0, 1, 3, 16'b0111, 1, 1);
        n_vec++;
        if (bus4.in_ready !== 4'b0000) begin
            n_err++; $display("FAIL fixed_idle_ready: got %b expected 0000", bus4.in_ready);
        end
        clock(0);
        n_vec++;
        if (bus4.out_valid !== 1'b0 || bus4.out_ch !== 2'd2) begin
            n_err++; $display("FAIL fixed_idle_out: got v=%b ch=%0d expected 0/2",
                              bus4.out_valid, bus4.out_ch);
        end
        apply(0, 0, 0, 0, 16'hFFFF, 1, 1);
        n_vec++;
        if (bus4.in_ready !== 4'b0010) begin
            n_err++; $display("FAIL fixed_resume_ready: got %b expected 0010", bus4.in_ready);
        end
        clock(0);
    endtask

    task automatic test_reset_mid;
        reset2(0);
        apply(0, 0, 0, 0, 16'hFFFF, 1, 0);
        clock(0);
        apply(0, 0, 0, 0, 16'hFFFF, 1, 0);
        clock(0);
        apply(0, 0, 0, 0, 16'hFFFF, 0, 0);
        clock(0);
        apply(0, 1, 0, 0, 16'hFFFF, 0, 0);
        n_vec++;
        if (bus4.in_ready !== 4'b0000) begin
            n_err++; $display("FAIL midrst_ready: got %b expected 0000", bus4.in_ready);
        end
        clock(0);
        n_vec++;
        if (bus4.out_valid !== 1'b0 || bus4.out_data !== 32'h0 || bus4.out_ch !== 2'd0) begin
            n_err++; $display("FAIL midrst_out: got v=%b ch=%0d d=%h expected all zero",
                              bus4.out_valid, bus4.out_ch, bus4.out_data);
        end
        apply(0, 0, 0, 0, 16'hFFFF, 1, 0);
        n_vec++;
        if (bus4.in_ready !== 4'b0001) begin
            n_err++; $display("FAIL midrst_ptr: got %b expected 0001", bus4.in_ready);
        end
        clock(0);
    endtask

    task automatic test_sel_out_of_range;
        reset2(1);
        for (int s = 5; s < 8; s++) begin
            apply(1, 0, 1, s, 16'hFFFF, 1, 0);
            n_vec++;
            if (bus5.in_ready !== 5'b00000) begin
                n_err++; $display("FAIL oor_ready sel=%0d: got %b expected 00000", s, bus5.in_ready);
            end
            clock(1);
            n_vec++;
            if (bus5.out_valid !== 1'b0) begin
                n_err++; $display("FAIL oor_out sel=%0d: got v=%b expected 0", s, bus5.out_valid);
            end
        end
        for (int i = 0; i < 10; i++) begin
            apply(1, 0, 0, 0, 16'hFFFF, 1, 1);
            clock(1);
            n_vec++;
            if (bus5.out_valid !== 1'b1 || bus5.out_ch !== 3'(i % 5) ||
                bus5.out_data !== (32'hA000_0000 | 32'(i % 5))) begin
                n_err++; $display("FAIL wrap5[%0d]: got v=%b ch=%0d d=%h expected ch=%0d",
                                  i, bus5.out_valid, bus5.out_ch, bus5.out_data, i % 5);
            end
        end
    endtask

    task automatic test_random(input int w, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            apply(w, $urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
                  int'($urandom_range(0, 7)), 16'($urandom()), $urandom_range(0, 3) != 0, 0);
            n_vec++;
            if (obs_ready(w) !== exp_rdy[w]) begin
                n_err++; $display("FAIL rand%0d_ready[%0d]: got %h expected %h",
                                  w, i, obs_ready(w), exp_rdy[w]);
            end
            clock(w);
            n_vec++;
            if (obs_out(w) !== exp_out(w)) begin
                n_err++; $display("FAIL rand%0d_out[%0d]: got %h expected %h (valid,ch,data)",
                                  w, i, obs_out(w), exp_out(w));
            end
        end
    endtask

    initial begin
        rst4 = 1'b1; rst5 = 1'b1;
        bus4.mode = 1'b0; bus4.sel = '0; bus4.in_valid = '0; bus4.in_data = '0; bus4.out_ready = 1'b1;
        bus5.mode = 1'b0; bus5.sel = '0; bus5.in_valid = '0; bus5.in_data = '0; bus5.out_ready = 1'b1;
        test_reset;
        test_fairness;
        test_skip_idle;
        test_backpressure;
        test_fixed;
        test_reset_mid;
        test_random(0, 400);
        test_sel_out_of_range;
        test_random(1, 400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
